// File: rtl/nibble_accum.sv
// Assembles an 8x8 unsigned product from four 4x4 partial products supplied by an
// external multiplier, steering its operand nibble muxes one step per clock.
module nibble_accum (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  pp_in,
  output logic        sel_a,
  output logic        sel_b,
  output logic [1:0]  step,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state, state_nxt;

  // Place a partial product at its nibble weight: A_lo*B_lo, A_hi*B_lo, A_lo*B_hi, A_hi*B_hi.
  function automatic logic [15:0] align_pp(input logic [7:0] pp, input logic [1:0] s);
    logic [15:0] r;
    case (s)
      2'd0:    r = {8'h00, pp};
      2'd1,
      2'd2:    r = {4'h0, pp, 4'h0};
      default: r = {pp, 8'h00};
    endcase
    return r;
  endfunction

  // Modulo-2^16 accumulate; the carry out is deliberately dropped.
  function automatic logic [15:0] wrap_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Selects and step decode purely from the registered state, so start never reaches the muxes.
  always_comb begin
    state_nxt = state;
    sel_a     = 1'b0;
    sel_b     = 1'b0;
    step      = 2'd0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = S0;
      S0: begin
        busy      = 1'b1;
        state_nxt = S1;
      end
      S1: begin
        busy      = 1'b1;
        sel_a     = 1'b1;
        step      = 2'd1;
        state_nxt = S2;
      end
      S2: begin
        busy      = 1'b1;
        sel_b     = 1'b1;
        step      = 2'd2;
        state_nxt = S3;
      end
      S3: begin
        busy      = 1'b1;
        sel_a     = 1'b1;
        sel_b     = 1'b1;
        step      = 2'd3;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? S0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator: first step overwrites, later steps add; untouched outside S0..S3.
  always_ff @(posedge clk) begin
    if (reset) begin
      product <= 16'h0000;
    end else if (busy) begin
      if (step == 2'd0) product <= align_pp(pp_in, step);
      else              product <= wrap_add(product, align_pp(pp_in, step));
    end
  end

endmodule
